// File: rtl/cpu_addr_seq.sv
// Operand address sequencer: resolves the effective address of one 6502-style
// operand by issuing the memory reads its addressing mode needs.
module cpu_addr_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  adr_mode,
    input  logic        index,
    input  logic [15:0] pc,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] ea,
    output logic [1:0]  len,
    output logic        err
);

    // Addressing-mode and index-select codes shared with the decoder.
    localparam logic [3:0] ADR_IMPL  = 4'd0;
    localparam logic [3:0] ADR_IMM   = 4'd1;
    localparam logic [3:0] ADR_ZPG   = 4'd2;
    localparam logic [3:0] ADR_ZPG_I = 4'd3;
    localparam logic [3:0] ADR_ABS   = 4'd4;
    localparam logic [3:0] ADR_ABS_I = 4'd5;
    localparam logic [3:0] ADR_X_IND = 4'd6;
    localparam logic [3:0] ADR_IND_Y = 4'd7;
    localparam logic [3:0] ADR_IND   = 4'd8;
    localparam logic [3:0] ADR_REL   = 4'd9;
    localparam logic [3:0] ADR_INVAL = 4'd15;
    localparam logic       ADR_INDEX_X = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_ISSUE = 2'd1,
        ST_RD_WAIT  = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Number of memory reads each mode needs.
    function automatic logic [2:0] f_nreads(input logic [3:0] mode);
        case (mode)
            ADR_ZPG, ADR_ZPG_I, ADR_REL: return 3'd1;
            ADR_ABS, ADR_ABS_I:          return 3'd2;
            ADR_X_IND, ADR_IND_Y:        return 3'd3;
            ADR_IND:                     return 3'd4;
            default:                     return 3'd0;
        endcase
    endfunction

    // Branch target: base plus a two's-complement byte offset, wrapping at 64K.
    function automatic logic [15:0] f_rel_target(input logic [15:0] base,
                                                 input logic [7:0]  off);
        logic signed [15:0] s_off;
        s_off = {{8{off[7]}}, off};
        return base + $unsigned(s_off);
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_mode;
    logic [7:0]  r_idx;
    logic [7:0]  r_x;
    logic [7:0]  r_y;
    logic [15:0] r_pc;
    logic [2:0]  r_nreads;
    logic [1:0]  r_step;
    logic [7:0]  r_d [4];
    logic [15:0] r_ea;
    logic [1:0]  r_len;
    logic        r_err;

    logic        w_accept;
    logic        w_last;
    logic [15:0] w_pc1;
    logic [7:0]  w_p;
    logic [7:0]  w_p1;
    logic [7:0]  w_b1;
    logic [7:0]  w_ptr_lo1;
    logic [7:0]  w_zpg_i;
    logic [15:0] w_rd_addr;
    logic [15:0] w_ea;
    logic [1:0]  w_len;
    logic        w_err;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_last    = (({1'b0, r_step} + 3'd1) == r_nreads);
    assign w_pc1     = r_pc + 16'd1;
    assign w_p       = r_d[0] + r_x;
    assign w_p1      = w_p + 8'd1;
    assign w_b1      = r_d[0] + 8'd1;
    assign w_ptr_lo1 = r_d[0] + 8'd1;
    assign w_zpg_i   = r_d[0] + r_idx;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Snapshot of the request so later input changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mode   <= adr_mode;
            r_idx    <= (index == ADR_INDEX_X) ? x : y;
            r_x      <= x;
            r_y      <= y;
            r_pc     <= pc;
            r_nreads <= f_nreads(adr_mode);
        end
    end

    // Read counter: which read of the sequence is in progress.
    always_ff @(posedge clk) begin
        if (!rst_n || w_accept) begin
            r_step <= 2'd0;
        end else if (r_state == ST_RD_WAIT) begin
            r_step <= r_step + 2'd1;
        end
    end

    // Capture returned data at the end of each wait cycle, slot by read number.
    always_ff @(posedge clk) begin
        if (r_state == ST_RD_WAIT) begin
            r_d[r_step] <= mem_rdata;
        end
    end

    // Result holding registers: keep the last result visible between operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ea  <= 16'h0000;
            r_len <= 2'd0;
            r_err <= 1'b0;
        end else if (r_state == ST_DONE) begin
            r_ea  <= w_ea;
            r_len <= w_len;
            r_err <= w_err;
        end
    end

    // Address of the current read, chosen by mode and read number.
    always_comb begin
        w_rd_addr = r_pc;
        case (r_mode)
            ADR_ABS, ADR_ABS_I: begin
                w_rd_addr = (r_step == 2'd0) ? r_pc : w_pc1;
            end
            ADR_X_IND: begin
                case (r_step)
                    2'd0:    w_rd_addr = r_pc;
                    2'd1:    w_rd_addr = {8'h00, w_p};
                    default: w_rd_addr = {8'h00, w_p1};
                endcase
            end
            ADR_IND_Y: begin
                case (r_step)
                    2'd0:    w_rd_addr = r_pc;
                    2'd1:    w_rd_addr = {8'h00, r_d[0]};
                    default: w_rd_addr = {8'h00, w_b1};
                endcase
            end
            ADR_IND: begin
                // The pointer high byte never increments: page-wrap on the pointer.
                case (r_step)
                    2'd0:    w_rd_addr = r_pc;
                    2'd1:    w_rd_addr = w_pc1;
                    2'd2:    w_rd_addr = {r_d[1], r_d[0]};
                    default: w_rd_addr = {r_d[1], w_ptr_lo1};
                endcase
            end
            default: w_rd_addr = r_pc;
        endcase
    end

    // Final effective address, operand length and error flag from captured bytes.
    always_comb begin
        w_ea  = 16'h0000;
        w_len = 2'd0;
        w_err = 1'b0;
        case (r_mode)
            ADR_IMPL: begin
                w_ea  = 16'h0000;
                w_len = 2'd0;
            end
            ADR_IMM: begin
                w_ea  = r_pc;
                w_len = 2'd1;
            end
            ADR_ZPG: begin
                w_ea  = {8'h00, r_d[0]};
                w_len = 2'd1;
            end
            ADR_ZPG_I: begin
                w_ea  = {8'h00, w_zpg_i};
                w_len = 2'd1;
            end
            ADR_ABS: begin
                w_ea  = {r_d[1], r_d[0]};
                w_len = 2'd2;
            end
            ADR_ABS_I: begin
                w_ea  = {r_d[1], r_d[0]} + {8'h00, r_idx};
                w_len = 2'd2;
            end
            ADR_X_IND: begin
                w_ea  = {r_d[2], r_d[1]};
                w_len = 2'd1;
            end
            ADR_IND_Y: begin
                w_ea  = {r_d[2], r_d[1]} + {8'h00, r_y};
                w_len = 2'd1;
            end
            ADR_IND: begin
                w_ea  = {r_d[3], r_d[2]};
                w_len = 2'd2;
            end
            ADR_REL: begin
                w_ea  = f_rel_target(w_pc1, r_d[0]);
                w_len = 2'd1;
            end
            ADR_INVAL: begin
                w_err = 1'b1;
            end
            default: begin
                w_err = 1'b1;
            end
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next   = r_state;
        mem_rd   = 1'b0;
        mem_addr = 16'h0000;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (f_nreads(adr_mode) != 3'd0) ? ST_RD_ISSUE : ST_DONE;
                end
            end
            ST_RD_ISSUE: begin
                mem_rd   = 1'b1;
                mem_addr = w_rd_addr;
                w_next   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                w_next = w_last ? ST_DONE : ST_RD_ISSUE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Results are live in the done cycle and held afterwards.
    assign ea  = (r_state == ST_DONE) ? w_ea  : r_ea;
    assign len = (r_state == ST_DONE) ? w_len : r_len;
    assign err = (r_state == ST_DONE) ? w_err : r_err;

endmodule
